// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner FSM states, direction key codes and the row/col keymap.
package keypad_pkg;
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
   localparam logic [3:0] KEY_UP    = 4'h2;
   localparam logic [3:0] KEY_LEFT  = 4'h4;
   localparam logic [3:0] KEY_RIGHT = 4'h6;
   localparam logic [3:0] KEY_DOWN  = 4'h8;
   // Nibble {row,col} holds the code, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
   localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      return KEYMAP[{row, col, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, resets to all-ones (idle rows).
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk_50MHz_i,
   input  logic         rst_sync_la_i,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk_50MHz_i) begin
      if (!rst_sync_la_i) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scan, debounce and hex encode.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 8
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DELAY   = 40,
   parameter int REPEAT_PERIOD  = 10
`endif
) (
   input  logic       clk_50MHz_i,
   input  logic       rst_sync_la_i,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] key_o,
   output logic       key_valid_o,
   output logic       key_held_o
);
   localparam int TW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   logic [3:0]    row_s;
   logic [TW-1:0] tick_cnt;
   logic [DW-1:0] db_cnt;
   logic [1:0]    col_idx;
   logic [1:0]    cap_row;
   logic [1:0]    low_row;
   logic          tick;
   logic          row_low;
   logic          db_done;
   state_t        state;
`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   logic [RW-1:0] rep_cnt;
   logic          rep_first;
   logic          rep_hit;
   assign rep_hit = int'(rep_cnt) + 1 == (rep_first ? REPEAT_DELAY : REPEAT_PERIOD);
`endif

   sync_2ff #(.W(4)) u_sync (
      .clk_50MHz_i  (clk_50MHz_i),
      .rst_sync_la_i(rst_sync_la_i),
      .d            (row_i),
      .q            (row_s)
   );

   assign tick    = tick_cnt == TW'(SCAN_DIV - 1);
   assign col_o   = ~(4'b0001 << col_idx);
   assign row_low = ~row_s[cap_row];
   assign low_row = ~row_s[0] ? 2'd0 : ~row_s[1] ? 2'd1 : ~row_s[2] ? 2'd2 : 2'd3;
   // The tick that leaves SCAN/HELD already saw the new level, so it counts as the first match
   assign db_done = int'(db_cnt) + 2 >= DEBOUNCE_TICKS;

   always_ff @(posedge clk_50MHz_i) begin
      if (!rst_sync_la_i) begin
         state       <= SCAN;
         tick_cnt    <= '0;
         db_cnt      <= '0;
         col_idx     <= '0;
         cap_row     <= '0;
         key_o       <= '0;
         key_valid_o <= 1'b0;
         key_held_o  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt     <= '0;
         rep_first   <= 1'b1;
`endif
      end else begin
         tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
         key_valid_o <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (row_s != 4'hF) begin
                     cap_row <= low_row;
                     db_cnt  <= '0;
                     state   <= DEBOUNCE;
                  end else col_idx <= col_idx + 1'b1;
               end
               DEBOUNCE: begin
                  if (!row_low) begin
                     col_idx <= col_idx + 1'b1;
                     state   <= SCAN;
                  end else if (db_done) begin
                     key_o       <= key_code(cap_row, col_idx);
                     key_valid_o <= 1'b1;
                     key_held_o  <= 1'b1;
                     state       <= HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt     <= '0;
                     rep_first   <= 1'b1;
`endif
                  end else db_cnt <= db_cnt + 1'b1;
               end
               HELD: begin
                  if (!row_low) begin
                     db_cnt <= '0;
                     state  <= RELEASE;
                  end
`ifdef KEYPAD_REPEAT_EN
                  else if (rep_hit) begin
                     key_valid_o <= 1'b1;
                     rep_cnt     <= '0;
                     rep_first   <= 1'b0;
                  end else rep_cnt <= rep_cnt + 1'b1;
`endif
               end
               RELEASE: begin
                  if (row_low) begin
                     state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt   <= '0;
                     rep_first <= 1'b1;
`endif
                  end else if (db_done) begin
                     key_held_o <= 1'b0;
                     col_idx    <= col_idx + 1'b1;
                     state      <= SCAN;
                  end else db_cnt <= db_cnt + 1'b1;
               end
               default: state <= SCAN;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad presses against a keymap scoreboard.
// Define KEYPAD_REPEAT_EN to also exercise auto-repeat.
module tb_keypad_scanner;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row, col, key;
   logic       valid, held;
   logic [3:0] pr [4];
   logic [3:0] codes [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
   logic [3:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Physical matrix: a row reads low when a pressed key sits in the driven column
   always_comb for (int r = 0; r < 4; r++) row[r] = ~|(pr[r] & ~col);

   keypad_scanner #(
      .SCAN_DIV(4), .DEBOUNCE_TICKS(3)
`ifdef KEYPAD_REPEAT_EN
      , .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
`endif
   ) dut (
      .clk_50MHz_i  (clk),
      .rst_sync_la_i(rst_n),
      .row_i        (row),
      .col_o        (col),
      .key_o        (key),
      .key_valid_o  (valid),
      .key_held_o   (held)
   );

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   function automatic logic [3:0] col_of(input int c);
      return 4'hF & ~(4'b0001 << c);
   endfunction

   task automatic wait_held(input logic lvl, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (held !== lvl && n < 400);
      chk(name, held, lvl);
   endtask

   task automatic wait_col_entry(input logic [3:0] c);
      int n = 0;
      do begin @(negedge clk); n++; end while (col === c && n < 100);
      do begin @(negedge clk); n++; end while (col !== c && n < 100);
      chk("col_entry", col, c);
   endtask

   always @(negedge clk) begin
      if (valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: key_o=%h, required no pulse", key);
         end else begin
            chk("pulse_key", key, exp_q.pop_front());
            chk("pulse_held", {3'b0, held}, 4'h1);
         end
      end
   end

   initial begin
      int r, c, k;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) pr[i] = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_col", col, 4'b1110);
      chk("rst_key", key, 4'h0);
      chk("rst_valid", {3'b0, valid}, 4'h0);
      chk("rst_held", {3'b0, held}, 4'h0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         repeat (4) @(negedge clk);
         chk("scan_col", col, col_of(i % 4));
      end
      // Reset while holding a key drops it silently
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      exp_q.push_back(codes[r*4+c]);
      pr[r][c] = 1'b1;
      wait_held(1'b1, "hold_before_reset");
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_mid_hold_held", {3'b0, held}, 4'h0);
      chk("reset_mid_hold_col", col, 4'b1110);
      pr[r][c] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // Randomized single presses
      for (int it = 0; it < 10; it++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         repeat ($urandom_range(1, 20)) @(negedge clk);
         exp_q.push_back(codes[r*4+c]);
         pr[r][c] = 1'b1;
         wait_held(1'b1, "press_held");
         chk("frozen_col", col, col_of(c));
         repeat ($urandom_range(0, 10)) @(negedge clk);
         chk("still_frozen", col, col_of(c));
         pr[r][c] = 1'b0;
         wait_held(1'b0, "release_held");
         chk("resume_col", col, col_of((c + 1) % 4));
         chk("key_kept", key, codes[r*4+c]);
      end
      // Press bounce: row 1 low for one tick at column 0
      wait_col_entry(4'b1110);
      pr[1][0] = 1'b1;
      repeat (4) @(negedge clk);
      pr[1][0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("bounce_col", col, 4'b1101);
      chk("bounce_held", {3'b0, held}, 4'h0);
      // Release bounce on "8"
      exp_q.push_back(4'h8);
      pr[2][1] = 1'b1;
      wait_held(1'b1, "hold8");
      pr[2][1] = 1'b0;
      repeat (4) @(negedge clk);
      pr[2][1] = 1'b1;
      repeat (12) @(negedge clk);
      chk("glitch_held", {3'b0, held}, 4'h1);
      chk("glitch_col", col, 4'b1101);
      pr[2][1] = 1'b0;
      wait_held(1'b0, "release8");
      chk("release8_col", col, 4'b1011);
      // "2" and "3" together: column 1 is reached first
      wait_col_entry(4'b1110);
      exp_q.push_back(4'h2);
      exp_q.push_back(4'h3);
      pr[0][1] = 1'b1;
      pr[0][2] = 1'b1;
      wait_held(1'b1, "hold2");
      chk("two_key_col", col, 4'b1101);
      pr[0][1] = 1'b0;
      wait_held(1'b0, "release2");
      wait_held(1'b1, "hold3");
      chk("key3_col", col, 4'b1011);
      pr[0][2] = 1'b0;
      wait_held(1'b0, "release3");
`ifdef KEYPAD_REPEAT_EN
      // Hold "4" for 12 ticks after acceptance: pulses at +0, +5, +7, +9, +11
      for (int i = 0; i < 5; i++) exp_q.push_back(4'h4);
      pr[1][0] = 1'b1;
      wait_held(1'b1, "hold4");
      repeat (48) @(negedge clk);
      pr[1][0] = 1'b0;
      wait_held(1'b0, "release4");
`endif
      repeat (40) @(negedge clk);
      k = exp_q.size();
      chk("pending_pulses", 4'(k), 4'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
